// File: rtl/control_unit.sv
// control_unit: hardwired sequencer for ALU_System.
// Fetches a 16-bit instruction as two bytes (LSB first) into IR, decodes it,
// runs one or two execute cycles and returns to fetch. HALT is terminal.
module control_unit #(
   parameter bit AUTO_START    = 1'b0,
   parameter bit HALT_ON_UNDEF = 1'b0
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        Start,
   input  logic [15:0] IROut,
   input  logic [3:0]  ALUOutFlag,
   output logic [2:0]  RF_O1Sel,
   output logic [2:0]  RF_O2Sel,
   output logic [1:0]  RF_FunSel,
   output logic [3:0]  RF_RegSel,
   output logic [3:0]  RF_TSel,
   output logic [3:0]  ALU_FunSel,
   output logic [1:0]  ARF_OutASel,
   output logic [1:0]  ARF_OutBSel,
   output logic [1:0]  ARF_FunSel,
   output logic [3:0]  ARF_RegSel,
   output logic        IR_LH,
   output logic        IR_Enable,
   output logic [1:0]  IR_Funsel,
   output logic        Mem_WR,
   output logic        Mem_CS,
   output logic [1:0]  MuxSelA,
   output logic [1:0]  MuxSelB,
   output logic        MuxCSel,
   output logic        Busy,
   output logic        Halted
);

   typedef enum logic [2:0] {
      StIdle, StInit, StFetchL, StFetchH, StDecode, StEx1, StEx2, StHalt
   } state_t;

   state_t     state_q;
   logic [3:0] opc;
   logic [1:0] rx;
   logic [1:0] ry;
   logic [3:0] rx_sel;
   logic       is_ld_imm, is_ld_dir, is_st, is_defined;
   logic       two_cycle, goes_halt;

   // The immediate reaches the datapath through IR directly; only Z is consulted.
   logic unused_inputs;
   assign unused_inputs = ^{ALUOutFlag[2:0], IROut[7:0]};

   // Instruction field decode
   always_comb begin
      opc        = IROut[15:12];
      rx         = IROut[11:10];
      ry         = IROut[9:8];
      rx_sel     = ~(4'b0001 << rx);
      is_ld_imm  = (opc == 4'h0) && (ry == 2'b00);
      is_ld_dir  = (opc == 4'h0) && (ry == 2'b01);
      is_st      = (opc == 4'h1);
      is_defined = is_ld_imm || is_ld_dir || ((opc >= 4'h1) && (opc <= 4'h9)) ||
                   (opc == 4'hF);
      two_cycle  = is_ld_dir || is_st;
      goes_halt  = (opc == 4'hF) || (!is_defined && HALT_ON_UNDEF);
   end

   // Sequencer state register; reset forces IDLE immediately
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= StIdle;
      end else begin
         case (state_q)
            StIdle:   if (Start || AUTO_START) state_q <= StInit;
            StInit:   state_q <= StFetchL;
            StFetchL: state_q <= StFetchH;
            StFetchH: state_q <= StDecode;
            StDecode: state_q <= StEx1;
            StEx1: begin
               if (goes_halt)      state_q <= StHalt;
               else if (two_cycle) state_q <= StEx2;
               else                state_q <= StFetchL;
            end
            StEx2:    state_q <= StFetchL;
            StHalt:   state_q <= StHalt;
            default:  state_q <= StIdle;
         endcase
      end
   end

   // Control word, combinational from state and IR
   always_comb begin
      RF_O1Sel    = 3'b000;
      RF_O2Sel    = 3'b000;
      RF_FunSel   = 2'b00;
      RF_RegSel   = 4'b1111;
      RF_TSel     = 4'b1111;
      ALU_FunSel  = 4'b0000;
      ARF_OutASel = 2'b00;
      ARF_OutBSel = 2'b00;
      ARF_FunSel  = 2'b00;
      ARF_RegSel  = 4'b1111;
      IR_LH       = 1'b0;
      IR_Enable   = 1'b0;
      IR_Funsel   = 2'b00;
      Mem_WR      = 1'b0;
      Mem_CS      = 1'b1;
      MuxSelA     = 2'b00;
      MuxSelB     = 2'b00;
      MuxCSel     = 1'b0;
      Busy        = (state_q != StIdle) && (state_q != StHalt);
      Halted      = (state_q == StHalt);

      case (state_q)
         StInit: begin
            ARF_RegSel = 4'b1100;
            ARF_FunSel = 2'b00;
         end
         StFetchL, StFetchH: begin
            ARF_OutBSel = 2'b11;
            Mem_CS      = 1'b0;
            IR_Enable   = 1'b1;
            IR_Funsel   = 2'b01;
            IR_LH       = (state_q == StFetchH);
            ARF_RegSel  = 4'b1110;
            ARF_FunSel  = 2'b11;
         end
         StEx1: begin
            case (opc)
               4'h0, 4'h1: begin
                  if (is_ld_imm) begin
                     MuxSelA   = 2'b10;
                     RF_FunSel = 2'b01;
                     RF_RegSel = rx_sel;
                  end else if (is_ld_dir || is_st) begin
                     MuxSelB    = 2'b10;
                     ARF_RegSel = 4'b1101;
                     ARF_FunSel = 2'b01;
                  end
               end
               4'h2, 4'h3, 4'h4, 4'h5: begin
                  MuxCSel   = 1'b1;
                  MuxSelA   = 2'b00;
                  RF_FunSel = 2'b01;
                  RF_RegSel = rx_sel;
                  RF_O1Sel  = {1'b1, rx};
                  RF_O2Sel  = {1'b1, ry};
                  case (opc)
                     4'h2:    ALU_FunSel = 4'b0100;
                     4'h3:    ALU_FunSel = 4'b0101;
                     4'h4:    ALU_FunSel = 4'b0111;
                     default: ALU_FunSel = 4'b1000;
                  endcase
               end
               4'h6, 4'h7: begin
                  RF_FunSel = (opc == 4'h6) ? 2'b11 : 2'b10;
                  RF_RegSel = rx_sel;
               end
               4'h8, 4'h9: begin
                  // BNE takes the branch only while Z from the last ALU op is clear
                  if ((opc == 4'h8) || !ALUOutFlag[3]) begin
                     MuxSelB    = 2'b10;
                     ARF_RegSel = 4'b1110;
                     ARF_FunSel = 2'b01;
                  end
               end
               default: ;
            endcase
         end
         StEx2: begin
            ARF_OutBSel = 2'b00;
            Mem_CS      = 1'b0;
            if (is_ld_dir) begin
               MuxSelA   = 2'b01;
               RF_FunSel = 2'b01;
               RF_RegSel = rx_sel;
            end else if (is_st) begin
               MuxCSel    = 1'b1;
               ALU_FunSel = 4'b0000;
               RF_O1Sel   = {1'b1, rx};
               Mem_WR     = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives control_unit against a behavioural ALU_System model.
// Every register/memory write the control word produces is popped from an
// expected-write queue and compared; programs are directed and hand-computed.
module tb_control_unit;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic        Start;
   logic [15:0] IROut;
   logic [3:0]  ALUOutFlag;
   logic [2:0]  RF_O1Sel, RF_O2Sel;
   logic [1:0]  RF_FunSel;
   logic [3:0]  RF_RegSel, RF_TSel;
   logic [3:0]  ALU_FunSel;
   logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
   logic [3:0]  ARF_RegSel;
   logic        IR_LH, IR_Enable;
   logic [1:0]  IR_Funsel;
   logic        Mem_WR, Mem_CS;
   logic [1:0]  MuxSelA, MuxSelB;
   logic        MuxCSel;
   logic        Busy, Halted;

   control_unit #(.AUTO_START(1'b0), .HALT_ON_UNDEF(1'b0)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .IROut(IROut),
      .ALUOutFlag(ALUOutFlag), .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel),
      .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel), .RF_TSel(RF_TSel),
      .ALU_FunSel(ALU_FunSel), .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel),
      .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
      .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
      .MuxSelA(MuxSelA), .MuxSelB(MuxSelB), .MuxCSel(MuxCSel), .Busy(Busy),
      .Halted(Halted)
   );

   always #5 Clock = ~Clock;

   // Datapath model state. Program bytes live in rom (stimulus-owned); stores
   // land in wmem (model-owned) and shadow rom once written.
   logic [7:0]  rom  [256];
   logic [7:0]  wmem [256];
   logic        wvld [256];
   logic [7:0]  rf   [4];
   logic [7:0]  pc, ar, sp;
   logic [15:0] ir;
   logic        z_flag;

   assign IROut      = ir;
   assign ALUOutFlag = {z_flag, 3'b000};

   localparam logic [1:0] KRf = 2'd0, KMem = 2'd1, KPc = 2'd2, KAr = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] idx;
      logic [7:0] data;
   } evt_t;

   evt_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [7:0] mem_rd(input logic [7:0] a);
      return wvld[a] ? wmem[a] : rom[a];
   endfunction

   function automatic logic [7:0] reg_next(input logic [7:0] cur, input logic [1:0] fun,
                                           input logic [7:0] ld);
      case (fun)
         2'b00:   return 8'h00;
         2'b01:   return ld;
         2'b10:   return cur - 8'd1;
         default: return cur + 8'd1;
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h required=%0h", name, got, want);
      end
   endtask

   task automatic expect_wr(input logic [1:0] k, input logic [7:0] idx, input logic [7:0] d);
      exp_q.push_back({k, idx, d});
   endtask

   task automatic observe(input logic [1:0] k, input logic [7:0] idx, input logic [7:0] d);
      evt_t got, want;
      got = {k, idx, d};
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_write got=%0h required=none", got);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            failures++;
            $display("FAIL write_seq got=%0h required=%0h", got, want);
         end
      end
   endtask

   task automatic load_word(input logic [7:0] a, input logic [15:0] w);
      rom[a]              = w[7:0];
      rom[8'(a + 8'd1)]   = w[15:8];
   endtask

   // Model + monitor: evaluate the control word at negedge, commit at posedge
   initial begin : model
      logic [7:0]  addr, memq, a_op, b_op, alu, mux_a, mux_b;
      logic [7:0]  rf_n [4];
      logic [7:0]  pc_n, ar_n, sp_n;
      logic [15:0] ir_n;
      logic        wr_en;
      logic [7:0]  wr_addr, wr_data;
      for (int i = 0; i < 4; i++) rf[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         wmem[i] = 8'h00;
         wvld[i] = 1'b0;
      end
      pc = 8'h00; ar = 8'h00; sp = 8'h00; ir = 16'h0000;
      forever begin
         @(negedge Clock);
         case (ARF_OutBSel)
            2'b00:   addr = ar;
            2'b11:   addr = pc;
            default: addr = sp;
         endcase
         memq = mem_rd(addr);
         a_op = MuxCSel ? rf[RF_O1Sel[1:0]] : pc;
         b_op = rf[RF_O2Sel[1:0]];
         case (ALU_FunSel)
            4'b0100: alu = a_op + b_op;
            4'b0101: alu = a_op - b_op;
            4'b0111: alu = a_op & b_op;
            4'b1000: alu = a_op | b_op;
            default: alu = a_op;
         endcase
         case (MuxSelA)
            2'b00:   mux_a = alu;
            2'b01:   mux_a = memq;
            2'b10:   mux_a = ir[7:0];
            default: mux_a = 8'h00;
         endcase
         mux_b = (MuxSelB == 2'b10) ? ir[7:0] : memq;
         for (int i = 0; i < 4; i++) begin
            rf_n[i] = rf[i];
            if (!RF_RegSel[i]) begin
               rf_n[i] = reg_next(rf[i], RF_FunSel, mux_a);
               if (Reset_n) observe(KRf, 8'(i), rf_n[i]);
            end
         end
         pc_n = pc; ar_n = ar; sp_n = sp;
         if (!ARF_RegSel[0]) begin
            pc_n = reg_next(pc, ARF_FunSel, mux_b);
            if (Reset_n && ARF_FunSel == 2'b01) observe(KPc, 8'h00, pc_n);
         end
         if (!ARF_RegSel[1]) begin
            ar_n = reg_next(ar, ARF_FunSel, mux_b);
            if (Reset_n && ARF_FunSel == 2'b01) observe(KAr, 8'h00, ar_n);
         end
         if (!ARF_RegSel[2]) sp_n = reg_next(sp, ARF_FunSel, mux_b);
         ir_n = ir;
         if (IR_Enable && IR_Funsel == 2'b01) begin
            if (IR_LH) ir_n[15:8] = memq;
            else       ir_n[7:0]  = memq;
         end
         wr_en   = !Mem_CS && Mem_WR;
         wr_addr = addr;
         wr_data = alu;
         if (Reset_n && wr_en) observe(KMem, wr_addr, wr_data);
         @(posedge Clock);
         if (Reset_n) begin
            for (int i = 0; i < 4; i++) rf[i] = rf_n[i];
            pc = pc_n; ar = ar_n; sp = sp_n; ir = ir_n;
            if (wr_en) begin
               wmem[wr_addr] = wr_data;
               wvld[wr_addr] = 1'b1;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int cyc;
      int busy_low;
      int quiet;
      bit seen;
      Reset_n = 1'b0;
      Start   = 1'b0;
      z_flag  = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;

      // Reset state
      repeat (2) @(negedge Clock);
      check("rst_busy", 16'(Busy), 16'h0);
      check("rst_halted", 16'(Halted), 16'h0);
      check("rst_cs", 16'(Mem_CS), 16'h1);
      check("rst_rf_regsel", 16'(RF_RegSel), 16'hF);
      Reset_n = 1'b1;
      repeat (3) @(negedge Clock);
      check("idle_wait_busy", 16'(Busy), 16'h0);

      // Reset in the middle of FETCH_H
      load_word(8'h00, 16'h0005);
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge Clock);
         if (IR_Enable && IR_LH) seen = 1'b1;
      end
      check("reach_fetch_h", 16'(seen), 16'h1);
      #2 Reset_n = 1'b0;
      #1;
      check("midrst_cs", 16'(Mem_CS), 16'h1);
      check("midrst_ir_en", 16'(IR_Enable), 16'h0);
      check("midrst_rf_regsel", 16'(RF_RegSel), 16'hF);
      check("midrst_arf_regsel", 16'(ARF_RegSel), 16'hF);
      check("midrst_busy", 16'(Busy), 16'h0);
      @(negedge Clock);
      Reset_n = 1'b1;
      repeat (2) @(negedge Clock);
      check("post_rst_idle", 16'(Busy), 16'h0);

      // Main program: loads, ALU ops, store, direct load, inc/dec, NOP, BRA, BNE, HLT
      load_word(8'h00, 16'h0005);  // LD R1 #5
      load_word(8'h02, 16'h0003);  // LD R1 #3
      load_word(8'h04, 16'h0404);  // LD R2 #4
      load_word(8'h06, 16'h2100);  // ADD R1,R2
      load_word(8'h08, 16'h1080);  // ST R1 -> 0x80
      load_word(8'h0A, 16'h0980);  // LD R3 <- M[0x80]
      load_word(8'h0C, 16'h3900);  // SUB R3,R2
      load_word(8'h0E, 16'h4100);  // AND R1,R2
      load_word(8'h10, 16'h5600);  // OR R2,R3
      load_word(8'h12, 16'h6C00);  // INC R4
      load_word(8'h14, 16'h7000);  // DEC R1
      load_word(8'h16, 16'hA000);  // undefined -> NOP
      load_word(8'h18, 16'h8030);  // BRA 0x30
      load_word(8'h30, 16'h9040);  // BNE 0x40 (Z = 0)
      load_word(8'h40, 16'hF000);  // HLT
      expect_wr(KRf, 8'd0, 8'h05);
      expect_wr(KRf, 8'd0, 8'h03);
      expect_wr(KRf, 8'd1, 8'h04);
      expect_wr(KRf, 8'd0, 8'h07);
      expect_wr(KAr, 8'd0, 8'h80);
      expect_wr(KMem, 8'h80, 8'h07);
      expect_wr(KAr, 8'd0, 8'h80);
      expect_wr(KRf, 8'd2, 8'h07);
      expect_wr(KRf, 8'd2, 8'h03);
      expect_wr(KRf, 8'd0, 8'h04);
      expect_wr(KRf, 8'd1, 8'h07);
      expect_wr(KRf, 8'd3, 8'h01);
      expect_wr(KRf, 8'd0, 8'h03);
      expect_wr(KPc, 8'd0, 8'h30);
      expect_wr(KPc, 8'd0, 8'h40);

      cyc = 0; busy_low = 0;
      Start = 1'b1;
      while (cyc < 200 && !Halted) begin
         @(negedge Clock);
         cyc++;
         Start = 1'b0;
         if (!Halted && !Busy) busy_low++;
      end
      // INIT + 13 single-EX x4 + 2 double-EX x5, plus the IDLE->INIT edge
      check("prog_cycles", 16'(cyc), 16'd64);
      check("busy_held", 16'(busy_low), 16'd0);
      check("queue_drained", 16'(exp_q.size()), 16'd0);
      check("final_pc", 16'(pc), 16'h42);
      check("mem_80", 16'(mem_rd(8'h80)), 16'h07);
      check("final_r1", 16'(rf[0]), 16'h03);
      check("final_r2", 16'(rf[1]), 16'h07);
      check("final_r3", 16'(rf[2]), 16'h03);
      check("final_r4", 16'(rf[3]), 16'h01);

      quiet = 0;
      repeat (20) begin
         @(negedge Clock);
         if (Halted && !Busy && Mem_CS && RF_RegSel == 4'hF && ARF_RegSel == 4'hF &&
             !IR_Enable) quiet++;
      end
      check("halt_quiet", 16'(quiet), 16'd20);

      // BNE not taken when Z = 1
      Reset_n = 1'b0;
      @(negedge Clock);
      check("halt_rst_busy", 16'(Halted), 16'h0);
      load_word(8'h00, 16'h9020);  // BNE 0x20
      load_word(8'h02, 16'hF000);  // HLT
      z_flag  = 1'b1;
      Reset_n = 1'b1;
      @(negedge Clock);
      cyc = 0;
      Start = 1'b1;
      while (cyc < 200 && !Halted) begin
         @(negedge Clock);
         cyc++;
         Start = 1'b0;
      end
      check("bne_cycles", 16'(cyc), 16'd10);
      check("bne_no_write", 16'(exp_q.size()), 16'd0);
      check("bne_pc", 16'(pc), 16'h04);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
